// File: rtl/mod_counter.sv
// Modulo up/down counter with runtime step/modulus, load and registered wrap pulse.
// Optional `define MOD_COUNTER_INCR_SHADOW_EN: step is taken from a shadow updated on load/wrap.
module mod_counter #(
    parameter int WIDTH      = 8,
    parameter int INCR_WIDTH = 8   // must not exceed WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  sat,
    input  logic [INCR_WIDTH-1:0] incr,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      ld_val,
    output logic [WIDTH-1:0]      count,
    output logic                  wrap
);

    localparam int W1 = WIDTH + 1;

    logic [WIDTH-1:0]      count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [INCR_WIDTH-1:0] incr_eff;

    logic [W1-1:0] count_ext, limit_ext, ld_ext, incr_ext;
    logic [W1-1:0] step, modulus, sum, nxt;

`ifdef MOD_COUNTER_INCR_SHADOW_EN
    logic [INCR_WIDTH-1:0] incr_q;
    logic                  shadow_ld;

    // Frequency changes only land at period boundaries or on an explicit load.
    assign shadow_ld = ld || (en && wrap_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            incr_q <= '0;
        end else if (shadow_ld) begin
            incr_q <= incr;
        end
    end

    assign incr_eff = incr_q;
`else
    assign incr_eff = incr;
`endif

    assign count_ext = {1'b0, count_q};
    assign limit_ext = {1'b0, limit};
    assign ld_ext    = {1'b0, ld_val};
    assign incr_ext  = {{(W1-INCR_WIDTH){1'b0}}, incr_eff};
    assign step      = (incr_ext > limit_ext) ? limit_ext : incr_ext;
    assign modulus   = limit_ext + 1'b1;
    assign sum       = count_ext + step;

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        nxt    = count_ext;
        wrap_d = 1'b0;
        if (ld) begin
            nxt = (ld_ext > limit_ext) ? limit_ext : ld_ext;
        end else if (en) begin
            if (count_ext > limit_ext) begin
                // Limit was lowered under the current count: restart at the period edge.
                nxt    = dir ? limit_ext : '0;
                wrap_d = 1'b1;
            end else if (step == '0) begin
                nxt = count_ext;
            end else if (!dir) begin
                if (sum <= limit_ext) begin
                    nxt = sum;
                end else if (!sat) begin
                    nxt    = sum - modulus;
                    wrap_d = 1'b1;
                end else begin
                    nxt    = limit_ext;
                    wrap_d = (count_ext != limit_ext);
                end
            end else begin
                if (count_ext >= step) begin
                    nxt = count_ext - step;
                end else if (!sat) begin
                    nxt    = (modulus - step) + count_ext;
                    wrap_d = 1'b1;
                end else begin
                    nxt    = '0;
                    wrap_d = (count_ext != '0);
                end
            end
        end
        count_d = nxt[WIDTH-1:0];
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: stimulus queues expected count/wrap, a monitor compares.
module tb_mod_counter;

    logic       clk, rst, en, dir, sat, ld, wrap;
    logic [7:0] incr, limit, ld_val, count;

    typedef struct {
        logic [7:0] c;
        logic       w;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod_counter #(.WIDTH(8), .INCR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .incr(incr),
        .limit(limit), .ld(ld), .ld_val(ld_val), .count(count), .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one expected entry per checked update, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".count"}, count, e.c);
            check({e.name, ".wrap"}, {7'd0, wrap}, {7'd0, e.w});
        end
    end

    task automatic set(input logic l, input logic [7:0] lv, input logic e, input logic d,
                       input logic s, input logic [7:0] inc, input logic [7:0] lim);
        ld = l; ld_val = lv; en = e; dir = d; sat = s; incr = inc; limit = lim;
    endtask

    // Called at a negedge with inputs already set; queues the result of the next edge.
    task automatic step(input logic [7:0] c, input logic w, input string nm);
        sb.push_back('{c: c, w: w, name: nm});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        set(0, 8'd0, 0, 0, 0, 8'd0, 8'd9);
        #1;
        check("reset.count", count, 8'h00);
        check("reset.wrap", {7'd0, wrap}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // T2: up wrap, limit 9 step 3
        set(1, 8'd0, 1, 0, 0, 8'd3, 8'd9);  step(8'd0, 0, "t2_ld");
        ld = 0;
        step(8'd3, 0, "t2_a"); step(8'd6, 0, "t2_b"); step(8'd9, 0, "t2_c");
        step(8'd2, 1, "t2_d"); step(8'd5, 0, "t2_e");

        // T3: down, wrap then saturate
        set(1, 8'd5, 1, 1, 0, 8'd4, 8'd9);  step(8'd5, 0, "t3_ld");
        ld = 0;
        step(8'd1, 0, "t3_a"); step(8'd7, 1, "t3_b"); step(8'd3, 0, "t3_c");
        set(1, 8'd5, 1, 1, 1, 8'd4, 8'd9);  step(8'd5, 0, "t3_ld2");
        ld = 0;
        step(8'd1, 0, "t3_d"); step(8'd0, 1, "t3_e"); step(8'd0, 0, "t3_f");

        // T4: load wins over enable and is clamped to limit; saturate at limit stays quiet
        set(1, 8'hF0, 1, 0, 0, 8'd4, 8'h80); step(8'h80, 0, "t4_ld");
        set(0, 8'hF0, 1, 0, 1, 8'd4, 8'h80); step(8'h80, 0, "t4_sat_hold");

        // T5: limit lowered below count
        set(1, 8'd200, 0, 0, 0, 8'd4, 8'hFF); step(8'd200, 0, "t5_ld");
        set(0, 8'd0, 1, 0, 0, 8'd4, 8'd50);
        step(8'd0, 1, "t5_drop"); step(8'd4, 0, "t5_a"); step(8'd8, 0, "t5_b");

        // Up saturation reaching the limit, then hold with en low
        set(1, 8'd48, 1, 0, 1, 8'd4, 8'd50); step(8'd48, 0, "sat_ld");
        ld = 0;
        step(8'd50, 1, "sat_hit"); step(8'd50, 0, "sat_stay");
        en = 0;
        step(8'd50, 0, "hold");

        // Full-range modulo 256, both directions
        set(1, 8'hFE, 1, 0, 0, 8'd3, 8'hFF); step(8'hFE, 0, "full_ld");
        ld = 0;
        step(8'h01, 1, "full_up");
        dir = 1;
        step(8'hFE, 1, "full_dn");

        // Step larger than limit is clamped to limit
        set(1, 8'd0, 1, 0, 0, 8'd20, 8'd9); step(8'd0, 0, "clamp_ld");
        ld = 0;
        step(8'd9, 0, "clamp_a"); step(8'd8, 1, "clamp_b");

        // T6: step change mid-period
        set(1, 8'd0, 1, 0, 0, 8'd3, 8'd9); step(8'd0, 0, "t6_ld");
        ld = 0;
        step(8'd3, 0, "t6_a"); step(8'd6, 0, "t6_b");
        incr = 8'd1;
`ifdef MOD_COUNTER_INCR_SHADOW_EN
        step(8'd9, 0, "t6_c"); step(8'd2, 1, "t6_d"); step(8'd3, 0, "t6_e"); step(8'd4, 0, "t6_f");
`else
        step(8'd7, 0, "t6_c"); step(8'd8, 0, "t6_d"); step(8'd9, 0, "t6_e");
`endif

        // T1: asynchronous reset between edges
        set(1, 8'h36, 1, 0, 0, 8'd1, 8'hFF); step(8'h36, 0, "t1_ld");
        ld = 0;
        step(8'h37, 0, "t1_cnt");
        #2;
        rst = 1'b0;
        #1;
        check("t1_async.count", count, 8'h00);
        check("t1_async.wrap", {7'd0, wrap}, 8'h00);
        @(negedge clk);
        check("t1_held.count", count, 8'h00);
        rst = 1'b1;
        en  = 0;
        step(8'h00, 0, "t1_post");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
